// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller built around one full_adder
//
// full_adder        : single-bit combinational full adder (a + b + ci -> {co,s})
// serial_adder_ctrl : computes {cout,sum} = op_a + op_b + cin one bit per cycle, LSB first
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request an addition (accepted only when idle)
//   op_a, op_b, cin     : operands, captured at the accepting edge
//   busy                : high while the addition is running (WIDTH cycles)
//   done                : one-cycle pulse when sum/cout are updated
//   sum, cout           : result of the last completed addition

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last;

  // Operands shift right so bit 0 always presents the bit being processed.
  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = (state == RUN);
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == LAST_CNT) begin
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    res_next            = res >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      // done mirrors the last-bit cycle, so it drops by itself one edge later.
      done <= last;
      if (accept) begin
        a_sh  <= op_a;
        b_sh  <= op_b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        res   <= res_next;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= res_next;
          cout <= fa_co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, busy1, done1, sum1, cout1;

  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct { int acc; logic [8:0] val; } exp_t;
  exp_t q8[$], q1[$];
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;
  int bl8 = 0, bl1 = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitors: compare on every done pulse, check busy length and result stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bl8 = 0;
    else begin
      if (busy8) begin
        bl8++;
        chk("hold8", {cout8, sum8}, last8);
      end else if (bl8 != 0) begin
        chk("busy8_len", bl8, 8);
        bl8 = 0;
      end
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("res8", {cout8, sum8}, e.val);
          chk("lat8", cyc - e.acc, 8);
          last8 = e.val;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bl1 = 0;
    else begin
      if (busy1) begin
        bl1++;
        chk("hold1", {cout1, sum1}, last1);
      end else if (bl1 != 0) begin
        chk("busy1_len", bl1, 1);
        bl1 = 0;
      end
      if (done1) begin
        if (q1.size() == 0) chk("done1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("res1", {cout1, sum1}, e.val[1:0]);
          chk("lat1", cyc - e.acc, 1);
          last1 = e.val[1:0];
        end
      end
    end
  end

  // Entered and left on a negedge. mode: 0 quiet, 1 random start/operand noise, 2 start pulse with 0x11 at RUN cycle 3.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input int mode);
    int t = 0;
    while (busy8 !== 1'b0) begin
      @(negedge clk);
      if (++t > 50) begin chk("issue8_timeout", 1, 0); return; end
    end
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back('{cyc + 1, {1'b0, a} + {1'b0, b} + 9'(c)});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start8 = (mode == 1) ? 1'($urandom) : (mode == 2 && k == 2);
      a8 = (mode == 2) ? 8'h11 : 8'($urandom);
      b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic c, input bit noise);
    int t = 0;
    while (busy1 !== 1'b0) begin
      @(negedge clk);
      if (++t > 50) begin chk("issue1_timeout", 1, 0); return; end
    end
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back('{cyc + 1, 9'(a) + 9'(b) + 9'(c)});
    @(negedge clk);
    start1 = noise ? 1'($urandom) : 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
    chk("rst_res8", {cout8, sum8}, 0);
    chk("rst_busy1", busy1, 0); chk("rst_res1", {done1, cout1, sum1}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy8", busy8, 0);

    issue8(8'h00, 8'h00, 1'b0, 0);
    issue8(8'hFF, 8'h01, 1'b0, 0);
    issue8(8'hA5, 8'h5A, 1'b1, 0);
    issue8(8'h3C, 8'h42, 1'b0, 2);

    // Reset at RUN cycle 4 of 0x7F + 0x01: nothing may complete afterwards.
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy8", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy8", busy8, 0); chk("mid_rst_done8", done8, 0);
    chk("mid_rst_res8", {cout8, sum8}, 0);
    last8 = '0; last1 = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy8", busy8, 0);
    chk("post_rst_res8", {cout8, sum8}, 0);

    // start held high across done: second op accepted one cycle after done.
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    acc = cyc + 1;
    q8.push_back('{acc, 9'h010});
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    q8.push_back('{acc + 9, 9'h100});
    repeat (9) @(negedge clk);
    chk("b2b_busy8", busy8, 1);
    start8 = 1'b0;
    repeat (9) @(negedge clk);

    for (int i = 0; i < 8; i++) issue1(i[2], i[1], i[0], 1'b0);
    for (int i = 0; i < 30; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      issue1(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    chk("pending8", q8.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on rising clk.
REQ-005 SHALL have port op_a  input  WIDTH  addend A, captured when start is accepted.
REQ-006 SHALL have port op_b  input  WIDTH  addend B, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking sum/cout valid and updated.
REQ-010 SHALL have port sum  output  WIDTH  result of the last completed addition.
REQ-011 SHALL have port cout  output  1  carry-out of the last completed addition.

Function
REQ-012 SHALL compute {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1), bit-serially LSB first.
REQ-013 SHALL use exactly one instance of the team's single-bit full_adder module as the only adder in the datapath.
REQ-014 SHALL keep an internal carry register that drives the full_adder cin and is loaded with its cout each processing cycle.
REQ-015 SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-016 SHALL accept start only when state is IDLE; at that edge E0 it captures op_a, op_b and cin, clears the bit counter and enters RUN.
REQ-017 SHALL process bit i (i = 0..WIDTH-1) on edge E(i+1), shifting the full_adder sum bit into an internal result shift register.
REQ-018 SHALL, on edge E(WIDTH), return to IDLE, load sum from the result register and cout from the final carry, and set done=1.
REQ-019 SHALL clear done on the following edge unless a new addition completes there (impossible for WIDTH>=1), giving exactly one cycle high.
REQ-020 SHALL give a latency of WIDTH cycles from the start-accepting edge to the done-asserting edge; busy high for exactly WIDTH cycles.
REQ-021 SHALL ignore start, op_a, op_b and cin while busy=1; captured operands remain unaffected.
REQ-022 SHALL hold sum and cout unchanged from the previous result during RUN; they update only at the done edge.
REQ-023 SHALL accept start in the same cycle done is high (state IDLE), allowing back-to-back operations with one idle cycle between busy periods.
REQ-024 SHALL size the bit counter as clog2(WIDTH+1) bits; counter never wraps during a legal operation.
REQ-025 SHALL operate correctly for WIDTH=1 (busy one cycle, done at E1).

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, result register=0.
REQ-027 SHALL, on reset asserted mid-RUN, abort the operation immediately with no done pulse and no sum/cout update after release.
REQ-028 SHALL ignore start on the first rising edge only if rst_n is still low; the first edge with rst_n=1 may accept start.

Verification
REQ-029 Bench SHALL cover (WIDTH=8): op_a=0x00, op_b=0x00, cin=0 -> after 8 cycles done=1, sum=0x00, cout=0.
REQ-030 Bench SHALL cover: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; op_a=0xA5, op_b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-031 Bench SHALL cover: start pulsed at cycle 3 of RUN with op_a=0x11 -> ignored; result reflects original operands, busy stays exactly 8 cycles.
REQ-032 Bench SHALL cover: rst_n low at cycle 4 of RUN of 0x7F+0x01 -> busy=0, done never pulses, sum=0x00, cout=0 after release.
REQ-033 Bench SHALL cover: start held high through done of 0x0F+0x01 then 0x80+0x80 -> sum=0x10 cout=0, then sum=0x00 cout=1, one idle cycle between.
REQ-034 Bench SHALL cover exhaustive WIDTH=1 sweep of all 8 {op_a,op_b,cin} combinations -> {cout,sum} matches full-adder truth table, done one cycle after start.
